// File: rtl/rv32v_lane_sequencer_if.sv
// Decode-to-execute bundle for rv32v_lane_sequencer: instruction intake and lane beat issue.
// Optional mask inputs appear when RV32V_SEQ_MASK_EN is defined.
interface rv32v_lane_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int VLMAX     = 32,
    parameter int OP_W      = 8
);
    localparam int IDX_W = $clog2(VLMAX + 1);

    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid && ready; valid may not depend on ready, and a raised valid holds its
    // payload stable until the transfer (only flush or reset may withdraw it).
    logic                 in_valid;
    logic                 in_ready;
    logic [IDX_W-1:0]     in_vl;
    logic [IDX_W-1:0]     in_vstart;
    logic [4:0]           in_vd;
    logic [4:0]           in_vs1;
    logic [4:0]           in_vs2;
    logic [OP_W-1:0]      in_op;
`ifdef RV32V_SEQ_MASK_EN
    logic                 in_vm;
    logic [VLMAX-1:0]     v0_mask;
`endif
    logic                 issue_valid;
    logic                 issue_ready;
    logic [IDX_W-1:0]     issue_idx;
    logic [NUM_LANES-1:0] issue_lane_en;
    logic                 issue_last;
    logic [4:0]           issue_vd;
    logic [4:0]           issue_vs1;
    logic [4:0]           issue_vs2;
    logic [OP_W-1:0]      issue_op;

    modport master (
        output in_valid, in_vl, in_vstart, in_vd, in_vs1, in_vs2, in_op,
`ifdef RV32V_SEQ_MASK_EN
        output in_vm, v0_mask,
`endif
        input  in_ready,
        input  issue_valid, issue_idx, issue_lane_en, issue_last,
        input  issue_vd, issue_vs1, issue_vs2, issue_op,
        output issue_ready
    );

    modport slave (
        input  in_valid, in_vl, in_vstart, in_vd, in_vs1, in_vs2, in_op,
`ifdef RV32V_SEQ_MASK_EN
        input  in_vm, v0_mask,
`endif
        output in_ready,
        output issue_valid, issue_idx, issue_lane_en, issue_last,
        output issue_vd, issue_vs1, issue_vs2, issue_op,
        input  issue_ready
    );
endinterface

// File: rtl/rv32v_lane_sequencer.sv
// Vector element sequencer: takes one instruction and issues its active element range as
// NUM_LANES-wide beats. Optional v0 masking is enabled with RV32V_SEQ_MASK_EN.
module rv32v_lane_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int VLMAX     = 32,
    parameter int OP_W      = 8
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      flush,
    rv32v_lane_sequencer_if.slave     bus,
    output logic                      busy,
    output logic                      done,
    output logic                      dbg_state
);
    localparam int IDX_W = $clog2(VLMAX + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, vl_q, vl_eff;
    logic [4:0]       vd_q, vs1_q, vs2_q;
    logic [OP_W-1:0]  op_q;
    logic             done_q;
    logic             accept, transfer, empty_instr, last_c;
    logic [IDX_W:0]   idx_ext, vl_ext;
`ifdef RV32V_SEQ_MASK_EN
    logic             vm_q;
    logic [VLMAX-1:0] mask_q, mask_sh;
`endif

    assign vl_eff      = (bus.in_vl > IDX_W'(VLMAX)) ? IDX_W'(VLMAX) : bus.in_vl;
    assign empty_instr = (bus.in_vstart >= vl_eff);
    assign accept      = bus.in_valid && (state_q == S_IDLE) && !flush;
    assign transfer    = (state_q == S_ISSUE) && bus.issue_ready;

    // One extra bit so idx + NUM_LANES cannot wrap near VLMAX.
    assign idx_ext = {1'b0, idx_q};
    assign vl_ext  = {1'b0, vl_q};
    assign last_c  = (idx_ext + (IDX_W+1)'(NUM_LANES)) >= vl_ext;

    always_ff @(posedge CLK) begin
        if (!nRST) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !empty_instr) state_d = S_ISSUE;
            S_ISSUE: begin
                if (flush)                   state_d = S_IDLE;
                else if (transfer && last_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction fields and element cursor; flush leaves the latched fields untouched.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            idx_q  <= '0;
            vl_q   <= '0;
            vd_q   <= '0;
            vs1_q  <= '0;
            vs2_q  <= '0;
            op_q   <= '0;
            done_q <= 1'b0;
`ifdef RV32V_SEQ_MASK_EN
            vm_q   <= 1'b0;
            mask_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                idx_q  <= bus.in_vstart;
                vl_q   <= vl_eff;
                vd_q   <= bus.in_vd;
                vs1_q  <= bus.in_vs1;
                vs2_q  <= bus.in_vs2;
                op_q   <= bus.in_op;
                done_q <= empty_instr;
`ifdef RV32V_SEQ_MASK_EN
                vm_q   <= bus.in_vm;
                mask_q <= bus.v0_mask;
`endif
            end else if (transfer && !flush) begin
                idx_q  <= idx_q + IDX_W'(NUM_LANES);
                done_q <= last_c;
            end
        end
    end

`ifdef RV32V_SEQ_MASK_EN
    assign mask_sh = mask_q >> idx_q;
`endif

    always_comb begin
        bus.in_ready    = (state_q == S_IDLE);
        busy            = (state_q == S_ISSUE);
        bus.issue_valid = (state_q == S_ISSUE);
        bus.issue_last  = (state_q == S_ISSUE) && last_c;
        bus.issue_idx   = idx_q;
        bus.issue_vd    = vd_q;
        bus.issue_vs1   = vs1_q;
        bus.issue_vs2   = vs2_q;
        bus.issue_op    = op_q;
        done            = done_q;
        dbg_state       = state_q;
        bus.issue_lane_en = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.issue_lane_en[i] = (state_q == S_ISSUE) &&
                                   ((idx_ext + (IDX_W+1)'(i)) < vl_ext)
`ifdef RV32V_SEQ_MASK_EN
                                   && (vm_q || mask_sh[i])
`endif
                                   ;
        end
    end
endmodule
